// File: rtl/cash_dispenser_if.sv
// Bus between the ATM controller (master) and the cash dispenser (slave):
// withdrawal request, cash refill strobe, and dispenser status/note pulses.
interface cash_dispenser_if #(
  parameter int WITHDRAW_SIZE = 15,
  parameter int ATM_CAP_SIZE  = 18
);
  // req is a level: the master holds it until busy rises, and the slave
  // accepts it only in IDLE on a cycle with no refill strobe.
  logic                     req;
  logic [WITHDRAW_SIZE-1:0] amount;
  logic                     refill;
  logic [ATM_CAP_SIZE-1:0]  cash_in;
  logic                     busy;
  logic                     note_200;
  logic                     note_100;
  logic                     note_50;
  logic                     done;
  logic                     err;
  logic [1:0]               err_code;
  logic [ATM_CAP_SIZE-1:0]  cash_level;

  modport master (
    output req, amount, refill, cash_in,
    input  busy, note_200, note_100, note_50, done, err, err_code, cash_level
  );

  modport slave (
    input  req, amount, refill, cash_in,
    output busy, note_200, note_100, note_50, done, err, err_code, cash_level
  );
endinterface

// File: rtl/cash_dispenser.sv
// Cash dispenser: validates a withdrawal against the cash level, then ejects
// notes greedily (200/100/50), one every DIVISOR cycles.
module cash_dispenser #(
  parameter int WITHDRAW_SIZE = 15,
  parameter int ATM_CAP_SIZE  = 18,
  parameter int DIVISOR       = 16,
  parameter int INIT_CASH     = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  cash_dispenser_if.slave   bus,
  output logic [2:0]        state_o
);

  localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int CW    = (WITHDRAW_SIZE > ATM_CAP_SIZE) ? WITHDRAW_SIZE : ATM_CAP_SIZE;
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [ATM_CAP_SIZE-1:0] CASH_MAX = '1;
  localparam logic [ATM_CAP_SIZE-1:0] CASH_RST = ATM_CAP_SIZE'(INIT_CASH);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DISPENSE, S_DONE, S_ERR
  } state_t;

  state_t                   state_q, state_d;
  logic [WITHDRAW_SIZE-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [ATM_CAP_SIZE-1:0]  cash_q, cash_d;
  logic [1:0]               code_q, code_d;

  logic [ATM_CAP_SIZE:0]    refill_sum;
  logic [WITHDRAW_SIZE-1:0] note_val;
  logic                     note_fire;
  logic                     amt_invalid;
  logic                     amt_too_big;

  assign refill_sum  = {1'b0, cash_q} + {1'b0, bus.cash_in};
  assign note_val    = (remaining_q >= WITHDRAW_SIZE'(200)) ? WITHDRAW_SIZE'(200) :
                       (remaining_q >= WITHDRAW_SIZE'(100)) ? WITHDRAW_SIZE'(100) :
                                                              WITHDRAW_SIZE'(50);
  assign note_fire   = (state_q == S_DISPENSE) && (div_q == DIV_LAST);
  assign amt_invalid = (remaining_q == '0) ||
                       ((remaining_q % WITHDRAW_SIZE'(50)) != '0);
  assign amt_too_big = CW'(remaining_q) > CW'(cash_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      div_q       <= '0;
      cash_q      <= CASH_RST;
      code_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      div_q       <= div_d;
      cash_q      <= cash_d;
      code_q      <= code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    div_d       = div_q;
    cash_d      = cash_q;
    code_d      = code_q;
    case (state_q)
      S_IDLE: begin
        // Refill wins the cycle; a held req is picked up once refill drops.
        if (bus.refill) begin
          cash_d = refill_sum[ATM_CAP_SIZE] ? CASH_MAX : refill_sum[ATM_CAP_SIZE-1:0];
        end else if (bus.req) begin
          remaining_d = bus.amount;
          div_d       = '0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (amt_invalid) begin
          code_d  = 2'b01;
          state_d = S_ERR;
        end else if (amt_too_big) begin
          code_d  = 2'b10;
          state_d = S_ERR;
        end else begin
          div_d   = '0;
          state_d = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (note_fire) begin
          div_d       = '0;
          remaining_d = remaining_q - note_val;
          cash_d      = cash_q - ATM_CAP_SIZE'(note_val);
          if (remaining_q == note_val) state_d = S_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.note_200   = note_fire && (note_val == WITHDRAW_SIZE'(200));
  assign bus.note_100   = note_fire && (note_val == WITHDRAW_SIZE'(100));
  assign bus.note_50    = note_fire && (note_val == WITHDRAW_SIZE'(50));
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);
  assign bus.err_code   = (state_q == S_ERR) ? code_q : 2'b00;
  assign bus.cash_level = cash_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_cash_dispenser.sv
// Bench for cash_dispenser: two instances (large and small initial cash)
// driven through one shared stimulus path and compared against a greedy model.
module tb_cash_dispenser;

  localparam int WS     = 15;
  localparam int CS     = 18;
  localparam int DIV    = 16;
  localparam int INIT_A = 200000;
  localparam int INIT_B = 300;
  localparam int CAP    = (1 << CS) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [2:0] state_a, state_b;

  cash_dispenser_if #(.WITHDRAW_SIZE(WS), .ATM_CAP_SIZE(CS)) bus_a ();
  cash_dispenser_if #(.WITHDRAW_SIZE(WS), .ATM_CAP_SIZE(CS)) bus_b ();

  cash_dispenser #(.WITHDRAW_SIZE(WS), .ATM_CAP_SIZE(CS), .DIVISOR(DIV), .INIT_CASH(INIT_A))
    dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a), .state_o(state_a));
  cash_dispenser #(.WITHDRAW_SIZE(WS), .ATM_CAP_SIZE(CS), .DIVISOR(DIV), .INIT_CASH(INIT_B))
    dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b), .state_o(state_b));

  // Stimulus goes to the instance picked by sel_b; observations come from it.
  logic          sel_b;
  logic          req_v, refill_v;
  logic [WS-1:0] amount_v;
  logic [CS-1:0] cash_in_v;

  assign bus_a.req     = req_v & ~sel_b;
  assign bus_b.req     = req_v & sel_b;
  assign bus_a.refill  = refill_v & ~sel_b;
  assign bus_b.refill  = refill_v & sel_b;
  assign bus_a.amount  = amount_v;
  assign bus_b.amount  = amount_v;
  assign bus_a.cash_in = cash_in_v;
  assign bus_b.cash_in = cash_in_v;

  logic          m_busy, m_n200, m_n100, m_n50, m_done, m_err;
  logic [1:0]    m_code;
  logic [CS-1:0] m_cash;
  assign m_busy = sel_b ? bus_b.busy       : bus_a.busy;
  assign m_n200 = sel_b ? bus_b.note_200   : bus_a.note_200;
  assign m_n100 = sel_b ? bus_b.note_100   : bus_a.note_100;
  assign m_n50  = sel_b ? bus_b.note_50    : bus_a.note_50;
  assign m_done = sel_b ? bus_b.done       : bus_a.done;
  assign m_err  = sel_b ? bus_b.err        : bus_a.err;
  assign m_code = sel_b ? bus_b.err_code   : bus_a.err_code;
  assign m_cash = sel_b ? bus_b.cash_level : bus_a.cash_level;

  // ---------------- scoreboard / model state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int model_a;
  int model_b;
  logic [WS-1:0] exp_q[$];

  int obs_val[$];
  int obs_cyc[$];
  int obs_end_cyc;
  int obs_err;
  int obs_code;
  int obs_multi;
  bit obs_timeout;

  // Greedy note sequence from the withdrawal rules; cash_after unchanged on error.
  task automatic model_txn(input int amt, input int cash_before,
                           output int code, output int cash_after);
    int rem;
    exp_q.delete();
    cash_after = cash_before;
    if (amt == 0 || (amt % 50) != 0) code = 1;
    else if (amt > cash_before)      code = 2;
    else begin
      code = 0;
      rem  = amt;
      while (rem > 0) begin
        if (rem >= 200)      begin exp_q.push_back(WS'(200)); rem -= 200; end
        else if (rem >= 100) begin exp_q.push_back(WS'(100)); rem -= 100; end
        else                 begin exp_q.push_back(WS'(50));  rem -= 50;  end
      end
      cash_after = cash_before - amt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_req(input int amt);
    @(posedge clk); #1;
    req_v    = 1'b1;
    amount_v = WS'(amt);
    @(posedge clk); #1;
  endtask

  task automatic do_refill(input int amt);
    @(posedge clk); #1;
    refill_v  = 1'b1;
    cash_in_v = CS'(amt);
    @(posedge clk); #1;
    refill_v  = 1'b0;
  endtask

  // Called just after the accepting edge; k counts cycles since acceptance,
  // so k-1 is the cycle index within DISPENSE.
  task automatic collect(input int max_cyc);
    int hi;
    obs_val.delete();
    obs_cyc.delete();
    obs_end_cyc = -1;
    obs_err     = 0;
    obs_code    = 0;
    obs_multi   = 0;
    obs_timeout = 1'b1;
    req_v       = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (k == 2) refill_v = 1'b0;
      hi = int'(m_n200) + int'(m_n100) + int'(m_n50) + int'(m_done) + int'(m_err);
      if (hi > 1) obs_multi++;
      if (m_n200) begin obs_val.push_back(200); obs_cyc.push_back(k - 1); end
      if (m_n100) begin obs_val.push_back(100); obs_cyc.push_back(k - 1); end
      if (m_n50)  begin obs_val.push_back(50);  obs_cyc.push_back(k - 1); end
      if (m_done) begin obs_end_cyc = k - 1; obs_timeout = 1'b0; break; end
      if (m_err)  begin
        obs_end_cyc = k - 1; obs_err = 1; obs_code = int'(m_code); obs_timeout = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus_a.busy); end
    n_cmp++; if ({bus_a.note_200, bus_a.note_100, bus_a.note_50} !== 3'b000) begin
      n_fail++; $display("FAIL reset_notes: got %b want 000", {bus_a.note_200, bus_a.note_100, bus_a.note_50}); end
    n_cmp++; if ({bus_a.done, bus_a.err, bus_a.err_code} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_done_err: got %b want 0000", {bus_a.done, bus_a.err, bus_a.err_code}); end
    n_cmp++; if (bus_a.cash_level !== CS'(INIT_A)) begin
      n_fail++; $display("FAIL reset_cash_a: got %0d want %0d", bus_a.cash_level, INIT_A); end
    n_cmp++; if (bus_b.cash_level !== CS'(INIT_B)) begin
      n_fail++; $display("FAIL reset_cash_b: got %0d want %0d", bus_b.cash_level, INIT_B); end
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    model_a = INIT_A;
    model_b = INIT_B;
  endtask

  task automatic test_withdrawals();
    int amts[$];
    int code;
    int cash_after;
    sel_b = 1'b0;
    amts  = {350, 75, 0, 50, 250};
    repeat (12) begin
      if ($urandom_range(0, 3) == 0) amts.push_back(int'($urandom_range(0, 1999)));
      else                           amts.push_back(50 * int'($urandom_range(1, 40)));
    end
    foreach (amts[t]) begin
      model_txn(amts[t], model_a, code, cash_after);
      start_req(amts[t]);
      collect(DIV * 45 + 10);
      n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL txn_timeout amt=%0d: got no done/err want completion", amts[t]); end
      n_cmp++; if (obs_err != (code != 0 ? 1 : 0)) begin
        n_fail++; $display("FAIL txn_err amt=%0d: got %0d want %0d", amts[t], obs_err, code != 0); end
      n_cmp++; if (obs_multi != 0) begin
        n_fail++; $display("FAIL txn_exclusive amt=%0d: got %0d overlapping cycles want 0", amts[t], obs_multi); end
      if (code != 0) begin
        n_cmp++; if (obs_code != code) begin
          n_fail++; $display("FAIL txn_code amt=%0d: got %0d want %0d", amts[t], obs_code, code); end
        n_cmp++; if (obs_end_cyc != 1) begin
          n_fail++; $display("FAIL txn_err_cycle amt=%0d: got %0d want 1", amts[t], obs_end_cyc); end
      end
      n_cmp++; if (obs_val.size() != exp_q.size()) begin
        n_fail++; $display("FAIL txn_note_count amt=%0d: got %0d want %0d", amts[t], obs_val.size(), exp_q.size()); end
      else begin
        foreach (exp_q[i]) begin
          n_cmp++; if (obs_val[i] != int'(exp_q[i]) || obs_cyc[i] != DIV * (i + 1)) begin
            n_fail++; $display("FAIL txn_note amt=%0d idx=%0d: got %0d@%0d want %0d@%0d",
                               amts[t], i, obs_val[i], obs_cyc[i], exp_q[i], DIV * (i + 1)); end
        end
        if (code == 0) begin
          n_cmp++; if (obs_end_cyc != DIV * exp_q.size() + 1) begin
            n_fail++; $display("FAIL txn_done_cycle amt=%0d: got %0d want %0d", amts[t], obs_end_cyc, DIV * exp_q.size() + 1); end
        end
      end
      model_a = cash_after;
      n_cmp++; if (m_cash !== CS'(model_a)) begin
        n_fail++; $display("FAIL txn_cash amt=%0d: got %0d want %0d", amts[t], m_cash, model_a); end
      if (t == 0) begin
        n_cmp++; if (m_cash !== CS'(199650)) begin
          n_fail++; $display("FAIL first_350_cash: got %0d want 199650", m_cash); end
      end
      @(negedge clk);
      n_cmp++; if (m_busy !== 1'b0) begin
        n_fail++; $display("FAIL txn_idle amt=%0d: got busy=%0b want 0", amts[t], m_busy); end
    end
  endtask

  task automatic test_refill_priority();
    sel_b = 1'b0;
    @(posedge clk); #1;
    refill_v  = 1'b1;
    cash_in_v = CS'(500);
    req_v     = 1'b1;
    amount_v  = WS'(50);
    @(posedge clk); #1;
    refill_v  = 1'b0;
    model_a   = (model_a + 500 > CAP) ? CAP : model_a + 500;
    n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy_refill_cycle: got %0b want 0", m_busy); end
    n_cmp++; if (m_cash !== CS'(model_a)) begin n_fail++; $display("FAIL prio_cash: got %0d want %0d", m_cash, model_a); end
    @(posedge clk); #1;
    n_cmp++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy_accept: got %0b want 1", m_busy); end
    collect(DIV * 2 + 10);
    model_a -= 50;
    n_cmp++; if (obs_val.size() != 1 || obs_timeout) begin
      n_fail++; $display("FAIL prio_notes: got %0d notes timeout=%0b want 1 note", obs_val.size(), obs_timeout); end
    n_cmp++; if (m_cash !== CS'(model_a)) begin n_fail++; $display("FAIL prio_cash_after: got %0d want %0d", m_cash, model_a); end
    @(negedge clk);
  endtask

  task automatic test_refill_busy();
    sel_b = 1'b0;
    start_req(100);
    refill_v  = 1'b1;
    cash_in_v = CS'(1000);
    collect(DIV * 2 + 10);
    model_a -= 100;
    n_cmp++; if (obs_val.size() != 1 || obs_timeout) begin
      n_fail++; $display("FAIL busy_refill_notes: got %0d notes timeout=%0b want 1", obs_val.size(), obs_timeout); end
    n_cmp++; if (m_cash !== CS'(model_a)) begin
      n_fail++; $display("FAIL busy_refill_cash: got %0d want %0d", m_cash, model_a); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    sel_b = 1'b0;
    do_refill(262000 - model_a);
    model_a = 262000;
    n_cmp++; if (m_cash !== CS'(262000)) begin n_fail++; $display("FAIL sat_pre: got %0d want 262000", m_cash); end
    do_refill(1000);
    model_a = CAP;
    n_cmp++; if (m_cash !== CS'(262143)) begin n_fail++; $display("FAIL sat_clip: got %0d want 262143", m_cash); end
  endtask

  task automatic test_reset_mid();
    int seen;
    int extra;
    sel_b = 1'b0;
    start_req(400);
    req_v = 1'b0;
    seen  = 0;
    for (int k = 0; k < DIV * 3; k++) begin
      @(negedge clk);
      if (m_n200) begin seen = 1; break; end
    end
    n_cmp++; if (seen != 1) begin n_fail++; $display("FAIL midrst_first_note: got none want note_200"); end
    repeat (5) @(posedge clk);
    #1 rst_n_a = 1'b0;
    #1;
    n_cmp++; if ({m_busy, m_n200, m_n100, m_n50, m_done, m_err, m_code} !== 8'h00) begin
      n_fail++; $display("FAIL midrst_outputs: got %b want 00000000", {m_busy, m_n200, m_n100, m_n50, m_done, m_err, m_code}); end
    n_cmp++; if (m_cash !== CS'(INIT_A)) begin n_fail++; $display("FAIL midrst_cash: got %0d want %0d", m_cash, INIT_A); end
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    model_a = INIT_A;
    extra   = 0;
    for (int k = 0; k < DIV * 4; k++) begin
      @(negedge clk);
      if (m_n200 || m_n100 || m_n50 || m_busy) extra++;
    end
    n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL midrst_after: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_insufficient();
    sel_b = 1'b1;
    start_req(350);
    collect(DIV * 2 + 10);
    n_cmp++; if (obs_err != 1 || obs_code != 2) begin
      n_fail++; $display("FAIL insuf_err: got err=%0d code=%0d want err=1 code=2", obs_err, obs_code); end
    n_cmp++; if (obs_val.size() != 0) begin n_fail++; $display("FAIL insuf_notes: got %0d want 0", obs_val.size()); end
    n_cmp++; if (m_cash !== CS'(INIT_B)) begin n_fail++; $display("FAIL insuf_cash: got %0d want %0d", m_cash, INIT_B); end
    @(negedge clk);
    do_refill(100);
    model_b = INIT_B + 100;
    n_cmp++; if (m_cash !== CS'(model_b)) begin n_fail++; $display("FAIL insuf_refill: got %0d want %0d", m_cash, model_b); end
    start_req(350);
    collect(DIV * 5 + 10);
    model_b -= 350;
    n_cmp++; if (obs_val.size() != 3 || obs_err != 0) begin
      n_fail++; $display("FAIL insuf_retry_notes: got %0d notes err=%0d want 3 notes", obs_val.size(), obs_err); end
    else begin
      n_cmp++; if (obs_val[0] != 200 || obs_val[1] != 100 || obs_val[2] != 50) begin
        n_fail++; $display("FAIL insuf_retry_order: got %0d,%0d,%0d want 200,100,50", obs_val[0], obs_val[1], obs_val[2]); end
    end
    n_cmp++; if (m_cash !== CS'(50)) begin n_fail++; $display("FAIL insuf_retry_cash: got %0d want 50", m_cash); end
    @(negedge clk);
    sel_b = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    sel_b     = 1'b0;
    req_v     = 1'b0;
    refill_v  = 1'b0;
    amount_v  = '0;
    cash_in_v = '0;
    test_reset();
    test_withdrawals();
    test_refill_priority();
    test_refill_busy();
    test_saturate();
    test_reset_mid();
    test_insufficient();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cash_dispenser.md
CASH_DISPENSER -- requirements
Module: cash_dispenser

Interface
REQ-001 Parameter WITHDRAW_SIZE, default 15: width of the requested withdrawal amount.
REQ-002 Parameter ATM_CAP_SIZE, default 18: width of the cash-level register.
REQ-003 Parameter DIVISOR, default 16: clock cycles per dispensed note.
REQ-004 Parameter INIT_CASH, default 200000: cash level loaded at reset; SHALL fit in ATM_CAP_SIZE bits.
REQ-005 clk  input  1: single system clock, all logic on rising edge.
REQ-006 rst_n  input  1: reset, asynchronous, active-low.
REQ-007 req  input  1: withdrawal request from ATM controller, held high until busy rises.
REQ-008 amount  input  WITHDRAW_SIZE: requested withdrawal amount, sampled when request accepted.
REQ-009 refill  input  1: one-cycle cash-load strobe.
REQ-010 cash_in  input  ATM_CAP_SIZE: amount added on refill.
REQ-011 busy  output  1: high whenever FSM not in IDLE.
REQ-012 note_200, note_100, note_50  output  1 each: one-cycle note-eject pulses.
REQ-013 done  output  1: one-cycle pulse, withdrawal completed.
REQ-014 err  output  1: one-cycle pulse, withdrawal rejected.
REQ-015 err_code  output  2: 01 invalid amount, 10 insufficient cash, 00 otherwise; valid with err.
REQ-016 cash_level  output  ATM_CAP_SIZE: current cash in machine (registered).

Function
REQ-017 FSM states SHALL be IDLE, CHECK, DISPENSE, DONE, ERR.
REQ-018 IDLE: req=1 and refill=0 SHALL latch amount into remaining register and move to CHECK next cycle.
REQ-019 IDLE: refill=1 SHALL have priority over req; req not accepted that cycle and stays pending while held.
REQ-020 Refill: cash_level <= cash_level + cash_in, saturating at 2^ATM_CAP_SIZE-1; refill outside IDLE ignored.
REQ-021 CHECK (one cycle): amount==0 or amount not multiple of 50 -> ERR with err_code 01.
REQ-022 CHECK: valid amount zero-extended to ATM_CAP_SIZE and greater than cash_level -> ERR with err_code 10; invalid-amount check takes precedence.
REQ-023 CHECK otherwise -> DISPENSE, divider counter cleared to 0.
REQ-024 DISPENSE: divider counts 0..DIVISOR-1; on count DIVISOR-1 exactly one note issued and counter wraps to 0.
REQ-025 Note selection greedy: remaining>=200 -> note_200; else >=100 -> note_100; else note_50.
REQ-026 On each note pulse, remaining and cash_level SHALL both decrease by the note value in the same clock edge.
REQ-027 When remaining reaches 0 after a note, next state DONE; DONE asserts done for one cycle, then IDLE.
REQ-028 ERR asserts err and err_code for one cycle, then IDLE; cash_level unchanged.
REQ-029 Latency: accept -> CHECK 1 cycle; first note DIVISOR cycles after entering DISPENSE; done one cycle after last note.
REQ-030 req in any non-IDLE state SHALL be ignored; no queuing.
REQ-031 At most one note output high in any cycle; note outputs, done, err never high together.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, busy=0, all note pulses=0, done=0, err=0, err_code=00, remaining=0, divider=0, cash_level=INIT_CASH.
REQ-033 Reset mid-DISPENSE SHALL abort the transaction; no further notes after rst_n deasserts until a new req.

Verification
REQ-034 INIT_CASH=200000, req amount=350 -> note_200, note_100, note_50 at DISPENSE cycles 16, 32, 48; done next cycle; cash_level=199650.
REQ-035 amount=75, then amount=0 -> err pulse, err_code=01 each, no note pulses, cash_level unchanged.
REQ-036 INIT_CASH=300, amount=350 -> err, err_code=10; then refill cash_in=100, amount=350 -> three notes, cash_level=50.
REQ-037 cash_level=262000, refill cash_in=1000 -> cash_level=262143; refill and req same IDLE cycle -> refill applied, req accepted next cycle.
REQ-038 amount=400, rst_n low 5 cycles after first note_200 -> outputs cleared, cash_level=INIT_CASH, no further notes after release.
